row_clear_sequencer: RTL and testbench

ROW_CLEAR_SEQUENCER -- requirements
Module: row_clear_sequencer

---
 rtl/row_clear_sequencer_pkg.sv | 32 +++
 rtl/row_full_detect.sv | 19 +
 rtl/row_clear_sequencer.sv | 177 +++++++++++++++++
 tb/tb_row_clear_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_clear_sequencer_pkg.sv
// rtl/row_clear_sequencer_pkg.sv - shared types and constants for the row clear sequencer
package row_clear_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_EVAL    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_FILL    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // A row with every cell holding the empty code 2'b11
  localparam logic [31:0] EMPTY_ROW = 32'h000F_FFFF;

  localparam logic [10:0] ROW0_ADDR_DEFAULT = 11'h002;

  localparam int NUM_COLS = 10;

  // Base points per pass indexed by the number of rows removed (0-4)
  function automatic logic [15:0] score_base(input logic [2:0] lines);
    case (lines)
      3'd1:    score_base = 16'd40;
      3'd2:    score_base = 16'd100;
      3'd3:    score_base = 16'd300;
      3'd4:    score_base = 16'd1200;
      default: score_base = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - flags a board row with no empty cell
module row_full_detect
  import row_clear_sequencer_pkg::*;
(
  input  logic [19:0] row_i,
  output logic        full_o
);

  // A row is full when no 2-bit column field carries the empty code
  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (row_i[2*c +: 2] == 2'b11) begin
        full_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/row_clear_sequencer.sv
// rtl/row_clear_sequencer.sv - removes full board rows in RAM, optional scoring via ROW_CLEAR_SCORE_EN
module row_clear_sequencer
  import row_clear_sequencer_pkg::*;
#(
  parameter logic [10:0] ROW0_ADDR = ROW0_ADDR_DEFAULT,
  parameter int          NUM_ROWS  = 20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        ram_gnt,
  output logic [10:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  input  logic [31:0] ram_rdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  lines_cleared
`ifdef ROW_CLEAR_SCORE_EN
  ,
  input  logic [4:0]  level,
  output logic [15:0] score_delta
`endif
);

  // Pointers carry one spare top bit so a decrement below row 0 is visible as the sign
  localparam int PW   = $clog2(NUM_ROWS);
  localparam int PTRW = PW + 1;
  localparam logic [PTRW-1:0] LAST_ROW = PTRW'(NUM_ROWS - 1);

  state_e          state_q, state_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     row_q, row_d;
  logic [2:0]      lines_q, lines_d;
  logic            advance;
  logic            row_full;

  row_full_detect u_row_full_detect (
    .row_i  (ram_rdata[19:0]),
    .full_o (row_full)
  );

  // Next-state logic: walk rows bottom-up, compacting non-full rows toward the bottom
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    lines_d  = lines_q;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_ptr_d = LAST_ROW;
          wr_ptr_d = LAST_ROW;
          cnt_d    = 3'd0;
          state_d  = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (ram_gnt) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (ram_gnt) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (ram_gnt) begin
          row_d = ram_rdata;
          if (row_full) begin
            if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
            advance = 1'b1;
          end else if (wr_ptr_q != rd_ptr_q) begin
            state_d = ST_WRITE;
          end else begin
            wr_ptr_d = wr_ptr_q - 1'b1;
            advance  = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (ram_gnt) begin
          wr_ptr_d = wr_ptr_q - 1'b1;
          advance  = 1'b1;
        end
      end
      ST_FILL: begin
        if (ram_gnt) begin
          wr_ptr_d = wr_ptr_q - 1'b1;
          if (wr_ptr_q == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        lines_d = cnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Finished with the current read row: move up or wrap up the pass
    if (advance) begin
      if (rd_ptr_q == '0) begin
        state_d = wr_ptr_d[PTRW-1] ? ST_DONE : ST_FILL;
      end else begin
        rd_ptr_d = rd_ptr_q - 1'b1;
        state_d  = ST_RD_REQ;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= 3'd0;
      row_q    <= 32'd0;
      lines_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      lines_q  <= lines_d;
    end
  end

  // RAM port drive; the read address is held through the wait and evaluate cycles
  always_comb begin
    ram_addr  = 11'd0;
    ram_wdata = 32'd0;
    ram_wren  = 1'b0;
    case (state_q)
      ST_RD_REQ, ST_RD_WAIT, ST_EVAL: begin
        ram_addr = ROW0_ADDR + 11'(rd_ptr_q);
      end
      ST_WRITE: begin
        ram_addr  = ROW0_ADDR + 11'(wr_ptr_q);
        ram_wdata = row_q;
        ram_wren  = ram_gnt;
      end
      ST_FILL: begin
        ram_addr  = ROW0_ADDR + 11'(wr_ptr_q);
        ram_wdata = EMPTY_ROW;
        ram_wren  = ram_gnt;
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign lines_cleared = lines_q;

`ifdef ROW_CLEAR_SCORE_EN
  logic [4:0]  level_q;
  logic [15:0] score_q;

  // Level is captured at start; points are computed once at the end of the pass
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level_q <= 5'd0;
      score_q <= 16'd0;
    end else begin
      if (state_q == ST_IDLE && start) level_q <= level;
      if (state_q == ST_DONE) score_q <= score_base(cnt_q) * (16'(level_q) + 16'd1);
    end
  end

  assign score_delta = score_q;
`endif

endmodule

// File: tb/tb_row_clear_sequencer.sv
// tb/tb_row_clear_sequencer.sv - self-checking bench for row_clear_sequencer
module tb_row_clear_sequencer;

  localparam logic [31:0] EMPTY = 32'h000F_FFFF;
  localparam int          ROW0  = 2;

  logic        CLK = 1'b0;
  logic        RESET, start, ram_gnt, ram_wren, busy, done;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [2:0]  lines_cleared;
  logic [4:0]  level;
  logic [15:0] score_delta;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:31];
  logic [31:0] img [0:19];
  logic [2:0]  exp_lines_q [$];
  logic [31:0] exp_rows_q [$];
  logic [15:0] exp_score_q [$];

  int          gnt_mode = 0;
  int          cyc = 0;
  int          wren_cnt = 0, gnt_viol = 0, done_cnt = 0, rd_cnt = 0, bad_addr = 0;
  logic [10:0] last_rd = 11'd0;

  always #5 CLK = ~CLK;

  row_clear_sequencer dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .start         (start),
    .ram_gnt       (ram_gnt),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_wren      (ram_wren),
    .ram_rdata     (ram_rdata),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared)
`ifdef ROW_CLEAR_SCORE_EN
    ,
    .level         (level),
    .score_delta   (score_delta)
`endif
  );

`ifndef ROW_CLEAR_SCORE_EN
  assign score_delta = 16'd0;
`endif

  // Board RAM port B: registered read, write only when granted
  always @(posedge CLK) begin
    if (ram_gnt) begin
      if (ram_wren) mem[ram_addr[4:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[4:0]];
    end
  end

  // Arbiter grant pattern
  initial begin
    ram_gnt = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      ram_gnt = (gnt_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // Bus activity monitor
  always @(negedge CLK) begin
    if (ram_wren) begin
      wren_cnt++;
      if (!ram_gnt) gnt_viol++;
      if (ram_addr < 11'(ROW0) || ram_addr > 11'(ROW0 + 19)) bad_addr++;
    end
    if (done) done_cnt++;
    if (busy && !ram_wren && ram_addr != 11'd0 && ram_addr != last_rd) begin
      rd_cnt++;
      last_rd = ram_addr;
    end
    if (!busy) last_rd = 11'd0;
  end

  function automatic bit is_full(input logic [31:0] row);
    for (int c = 0; c < 10; c++) if (row[2*c +: 2] == 2'b11) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] base_pts(input int n);
    case (n)
      1: return 16'd40;
      2: return 16'd100;
      3: return 16'd300;
      4: return 16'd1200;
      default: return 16'd0;
    endcase
  endfunction

  task automatic load_image();
    for (int i = 0; i < 20; i++) mem[ROW0 + i] <= img[i];
    @(negedge CLK);
  endtask

  // Reference model: keep non-full rows in order at the bottom, pad the top with empty rows
  task automatic push_expect(input logic [4:0] lvl);
    logic [31:0] tmp [0:19];
    int k, n;
    k = 19;
    n = 0;
    for (int r = 19; r >= 0; r--) begin
      if (!is_full(img[r])) begin
        tmp[k] = img[r];
        k--;
      end else begin
        n++;
      end
    end
    for (int j = k; j >= 0; j--) tmp[j] = EMPTY;
    for (int i = 0; i < 20; i++) exp_rows_q.push_back(tmp[i]);
    if (n > 4) n = 4;
    exp_lines_q.push_back(3'(n));
    exp_score_q.push_back(16'(base_pts(n) * (int'(lvl) + 1)));
  endtask

  task automatic do_pass(input logic [4:0] lvl, output bit finished);
    @(negedge CLK);
    start = 1'b1;
    level = lvl;
    @(negedge CLK);
    start = 1'b0;
    finished = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    start = 1'b0;
    level = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    repeat (3) @(negedge CLK);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
    vectors++; if (ram_addr !== 11'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
    vectors++; if (ram_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", ram_wdata); end
    vectors++; if (lines_cleared !== 3'd0) begin miscompares++; $display("FAIL reset_lines: got %0d expected 0", lines_cleared); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_no_full();
    bit fin;
    int w0, r0;
    logic [31:0] e;
    for (int i = 0; i < 20; i++) img[i] = 32'h0000_0003 | (32'(i) << 4);
    load_image();
    push_expect(5'd0);
    w0 = wren_cnt;
    r0 = rd_cnt;
    do_pass(5'd0, fin);
    vectors++; if (!fin) begin miscompares++; $display("FAIL no_full_timeout: got no done expected done"); end
    vectors++; if (wren_cnt - w0 != 0) begin miscompares++; $display("FAIL no_full_wren: got %0d expected 0", wren_cnt - w0); end
    vectors++; if (rd_cnt - r0 != 20) begin miscompares++; $display("FAIL no_full_reads: got %0d expected 20", rd_cnt - r0); end
    e = {29'd0, exp_lines_q.pop_front()};
    vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL no_full_lines: got %0d expected %0d", lines_cleared, e); end
    void'(exp_score_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      e = exp_rows_q.pop_front();
      vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL no_full_row%0d: got %h expected %h", i, mem[ROW0 + i], e); end
    end
  endtask

  task automatic one_full_image();
    for (int i = 0; i < 19; i++) img[i] = 32'h0000_0003 | (32'(i) << 4) | (32'(i) << 24);
    img[19] = 32'hA500_0000 | 32'h0005_5555;
  endtask

  task automatic test_one_full();
    bit fin;
    logic [31:0] e;
    one_full_image();
    load_image();
    push_expect(5'd0);
    do_pass(5'd0, fin);
    vectors++; if (!fin) begin miscompares++; $display("FAIL one_full_timeout: got no done expected done"); end
    e = {29'd0, exp_lines_q.pop_front()};
    vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL one_full_lines: got %0d expected %0d", lines_cleared, e); end
    vectors++; if (lines_cleared !== 3'd1) begin miscompares++; $display("FAIL one_full_lines_const: got %0d expected 1", lines_cleared); end
    void'(exp_score_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      e = exp_rows_q.pop_front();
      vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL one_full_row%0d: got %h expected %h", i, mem[ROW0 + i], e); end
    end
  endtask

  task automatic test_four_full();
    bit fin;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) img[i] = 32'h000C_0000 | (32'(i) << 2);
    img[16] = 32'h0000_0000;
    img[17] = 32'h000A_AAAA;
    img[18] = 32'h0005_5555;
    img[19] = 32'hFFF6_2418;
    load_image();
    push_expect(5'd2);
    do_pass(5'd2, fin);
    vectors++; if (!fin) begin miscompares++; $display("FAIL four_full_timeout: got no done expected done"); end
    e = {29'd0, exp_lines_q.pop_front()};
    vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL four_full_lines: got %0d expected %0d", lines_cleared, e); end
    e = {16'd0, exp_score_q.pop_front()};
`ifdef ROW_CLEAR_SCORE_EN
    vectors++; if (32'(score_delta) !== e) begin miscompares++; $display("FAIL four_full_score: got %0d expected %0d", score_delta, e); end
`endif
    for (int i = 0; i < 20; i++) begin
      e = exp_rows_q.pop_front();
      vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL four_full_row%0d: got %h expected %h", i, mem[ROW0 + i], e); end
    end
  endtask

  task automatic test_gnt_throttle();
    bit fin;
    int v0, b0;
    logic [31:0] e;
    one_full_image();
    load_image();
    push_expect(5'd0);
    v0 = gnt_viol;
    b0 = bad_addr;
    gnt_mode = 1;
    do_pass(5'd0, fin);
    gnt_mode = 0;
    @(negedge CLK);
    vectors++; if (!fin) begin miscompares++; $display("FAIL throttle_timeout: got no done expected done"); end
    vectors++; if (gnt_viol - v0 != 0) begin miscompares++; $display("FAIL throttle_wren_no_gnt: got %0d expected 0", gnt_viol - v0); end
    vectors++; if (bad_addr - b0 != 0) begin miscompares++; $display("FAIL throttle_addr_range: got %0d expected 0", bad_addr - b0); end
    e = {29'd0, exp_lines_q.pop_front()};
    vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL throttle_lines: got %0d expected %0d", lines_cleared, e); end
    void'(exp_score_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      e = exp_rows_q.pop_front();
      vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL throttle_row%0d: got %h expected %h", i, mem[ROW0 + i], e); end
    end
  endtask

  task automatic test_start_while_busy();
    bit fin;
    int d0;
    logic [31:0] e;
    for (int i = 0; i < 20; i++) img[i] = (i % 5 == 0) ? (32'h0000_0000 | 32'(i)) : (32'h0000_C000 | 32'(i));
    load_image();
    push_expect(5'd0);
    d0 = done_cnt;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    fin = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (done) begin fin = 1'b1; break; end
      @(negedge CLK);
    end
    repeat (60) @(negedge CLK);
    vectors++; if (!fin) begin miscompares++; $display("FAIL busy_start_timeout: got no done expected done"); end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL busy_start_done_pulses: got %0d expected 1", done_cnt - d0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
    e = {29'd0, exp_lines_q.pop_front()};
    vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL busy_start_lines: got %0d expected %0d", lines_cleared, e); end
    void'(exp_score_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      e = exp_rows_q.pop_front();
      vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL busy_start_row%0d: got %h expected %h", i, mem[ROW0 + i], e); end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit fin, seen;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) img[i] = 32'h0003_0000 | (32'(i) << 4);
    for (int i = 16; i < 20; i++) img[i] = 32'h0000_0000 | (32'(i) << 2);
    load_image();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (ram_wren && ram_wdata === EMPTY) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL mid_fill_reached: got no fill write expected fill write"); end
    RESET = 1'b1;
    @(negedge CLK);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_fill_busy: got %b expected 0", busy); end
    vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL mid_fill_wren: got %b expected 0", ram_wren); end
    vectors++; if (ram_addr !== 11'd0) begin miscompares++; $display("FAIL mid_fill_addr: got %h expected 0", ram_addr); end
    vectors++; if (lines_cleared !== 3'd0) begin miscompares++; $display("FAIL mid_fill_lines: got %0d expected 0", lines_cleared); end
    RESET = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 20; i++) img[i] = mem[ROW0 + i];
    img[0] = 32'h0001_5555;
    load_image();
    push_expect(5'd1);
    do_pass(5'd1, fin);
    vectors++; if (!fin) begin miscompares++; $display("FAIL after_reset_timeout: got no done expected done"); end
    e = {29'd0, exp_lines_q.pop_front()};
    vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL after_reset_lines: got %0d expected %0d", lines_cleared, e); end
    e = {16'd0, exp_score_q.pop_front()};
`ifdef ROW_CLEAR_SCORE_EN
    vectors++; if (32'(score_delta) !== e) begin miscompares++; $display("FAIL after_reset_score: got %0d expected %0d", score_delta, e); end
`endif
    for (int i = 0; i < 20; i++) begin
      e = exp_rows_q.pop_front();
      vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL after_reset_row%0d: got %h expected %h", i, mem[ROW0 + i], e); end
    end
  endtask

  task automatic test_random();
    bit fin;
    logic [31:0] e, r;
    logic [4:0]  lvl;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) begin
        r = {$urandom_range(0, 4095), 20'd0};
        for (int c = 0; c < 10; c++) r[2*c +: 2] = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 2) != 0) r[2*$urandom_range(0, 9) +: 2] = 2'b11;
        img[i] = r;
      end
      lvl = 5'($urandom_range(0, 31));
      load_image();
      push_expect(lvl);
      do_pass(lvl, fin);
      vectors++; if (!fin) begin miscompares++; $display("FAIL random%0d_timeout: got no done expected done", p); end
      e = {29'd0, exp_lines_q.pop_front()};
      vectors++; if (32'(lines_cleared) !== e) begin miscompares++; $display("FAIL random%0d_lines: got %0d expected %0d", p, lines_cleared, e); end
      e = {16'd0, exp_score_q.pop_front()};
`ifdef ROW_CLEAR_SCORE_EN
      vectors++; if (32'(score_delta) !== e) begin miscompares++; $display("FAIL random%0d_score: got %0d expected %0d", p, score_delta, e); end
`endif
      for (int i = 0; i < 20; i++) begin
        e = exp_rows_q.pop_front();
        vectors++; if (mem[ROW0 + i] !== e) begin miscompares++; $display("FAIL random%0d_row%0d: got %h expected %h", p, i, mem[ROW0 + i], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_full();
    test_one_full();
    test_four_full();
    test_gnt_throttle();
    test_start_while_busy();
    test_reset_mid_fill();
    test_random();
    vectors++; if (gnt_viol != 0) begin miscompares++; $display("FAIL total_wren_no_gnt: got %0d expected 0", gnt_viol); end
    vectors++; if (bad_addr != 0) begin miscompares++; $display("FAIL total_addr_range: got %0d expected 0", bad_addr); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
